dunc16_mem_port: RTL and testbench
==================================

Name: dunc16_mem_port

Overview:
- Word-addressed 16-bit memory port directly downstream of the dunc16 core.
- Consumes the core's ADDRESS, WRITE and write data (AC_OUT on STA); produces MMO for instruction fetch and LDA.
- Adds a REQ/ACK handshake with a programmable wait-state count, so the core can be timed against slower memories.
- Contains the storage array itself: single port, one access in flight.

Parameters:
- ADDR_W, 8, number of ADDRESS bits decoded; array depth is 2**ADDR_W words.
- WAIT_STATES, 1, extra cycles between request acceptance and completion (0..15).
- WPROT_LIMIT, 16'h0010, first writable word address (used only with the optional feature).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset (asserted = 0).
- REQ  input  1  access request from the core; sampled only in IDLE.
- WRITE  input  1  1 = write, 0 = read; qualified by REQ.
- ADDRESS  input  16  word address; only bits [ADDR_W-1:0] are used.
- DATA_IN  input  16  write data.
- MMO  output  16  read data; holds its value until the next completed read.
- ACK  output  1  one-cycle completion strobe.
- BUSY  output  1  high from acceptance until the completion edge.
- WPROT_ERR  output  1  one-cycle strobe on a rejected write (optional feature only; otherwise tied 0).

Behaviour:
- Reset (RESET=0, async): state=IDLE, ACK=0, BUSY=0, MMO=16'h0000, WPROT_ERR=0, wait counter=0. Array contents are not cleared.
- Reset mid-access: the latched request is abandoned and the array is left unmodified.
- States: IDLE, BUSY.
- IDLE, REQ=1 at an edge:
  - Latch ADDRESS[ADDR_W-1:0], WRITE and DATA_IN.
  - Counter=WAIT_STATES, BUSY=1, go to BUSY.
- IDLE, REQ=0: no change.
- BUSY, counter≠0: decrement the counter; inputs are ignored, so REQ changes have no effect.
- BUSY, counter=0, at the edge:
  - Write: array[addr] <= latched data.
  - Read: MMO <= array[addr].
  - ACK=1 for exactly one cycle, BUSY=0, return to IDLE.
- Latency: if REQ is sampled at edge N, ACK is high during the cycle following edge N+WAIT_STATES+1. MMO is valid in that same cycle.
- Back-to-back:
  - A REQ held high while ACK=1 is accepted at the edge where ACK falls.
  - Sustained throughput is one access per WAIT_STATES+2 edges.
- Address aliasing: upper ADDRESS bits are ignored (e.g. with ADDR_W=8, 16'h0105 maps to word 8'h05).
- A write followed by a read of the same address returns the new data; there is no forwarding hazard, because accesses are serialised.
- MMO is unchanged by writes and by rejected writes.
- WAIT_STATES values above 15 are illegal.

Optional Feature:
- Macro: DUNC16_MEM_WPROT_EN.
- Defined:
  - A write whose decoded address is below WPROT_LIMIT[ADDR_W-1:0] completes with normal timing and ACK, but the array is not modified.
  - WPROT_ERR pulses high in the same cycle as that ACK.
  - Reads are unaffected.
- Undefined: all writes are performed, and WPROT_ERR is constant 0.

Test Plan:
- Reset, WAIT_STATES=1: hold RESET=0 for 2 cycles then release -> ACK=0, BUSY=0, MMO=16'h0000; no ACK for 5 idle cycles with REQ=0.
- Write then read: REQ/WRITE=1, ADDRESS=16'h0020, DATA_IN=16'hBEEF, then REQ/WRITE=0 at 16'h0020 -> each ACK arrives 2 edges after acceptance; MMO=16'hBEEF in the read's ACK cycle.
- Aliasing, ADDR_W=8: write 16'h1234 to 16'h0105, then read 16'h0005 -> MMO=16'h1234.
- Back-to-back with REQ held high across 3 reads (WAIT_STATES=0) -> ACK high every second cycle; BUSY=0 only during the ACK cycles; MMO updates in each ACK cycle.
- Reset mid-write: accept a write of 16'hAAAA to 16'h0030, assert RESET=0 before ACK, release, then read 16'h0030 -> returns the prior contents (16'h5555 preloaded); no ACK is issued for the aborted write.
- Write protect, with DUNC16_MEM_WPROT_EN defined: write 16'hFFFF to 16'h0004 (preloaded 16'h0001) -> ACK and WPROT_ERR pulse together; a following read returns 16'h0001. Without the macro -> the read returns 16'hFFFF and WPROT_ERR stays 0.

Source files
------------

// File: rtl/dunc16_mem_port.sv
// -----------------------------------------------------------------------------
// dunc16_mem_port
//
// Word-addressed 16-bit memory port that sits directly downstream of the dunc16
// core. It owns the single-port storage array and serialises accesses through a
// REQ/ACK handshake. A fixed number of wait states is inserted between
// acceptance and completion, so the core can be timed against slower memories.
//
// Parameters
//   ADDR_W       ADDRESS bits decoded; the array holds 2**ADDR_W words.
//   WAIT_STATES  Extra cycles between acceptance and completion. Legal range is
//                0..15, because the wait counter is 4 bits wide.
//   WPROT_LIMIT  First writable word address. It is used only when write
//                protection is compiled in.
//
// Ports
//   CLK        in   system clock; all state changes on the rising edge
//   RESET      in   asynchronous reset, active low
//   REQ        in   access request; sampled only while idle
//   WRITE      in   1 = write, 0 = read; qualified by REQ
//   ADDRESS    in   word address; only [ADDR_W-1:0] is decoded
//   DATA_IN    in   write data
//   MMO        out  read data; holds its value until the next completed read
//   ACK        out  one-cycle completion strobe
//   BUSY       out  high from acceptance until the completion edge
//   WPROT_ERR  out  one-cycle strobe, in the ACK cycle, on a rejected write
//
// Optional feature
//   Define DUNC16_MEM_WPROT_EN to enable write protection. A write below
//   WPROT_LIMIT then completes with normal timing and ACK, but it leaves the
//   array untouched and pulses WPROT_ERR. Without the macro, every write is
//   performed and WPROT_ERR is constant 0.
// -----------------------------------------------------------------------------
module dunc16_mem_port #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] WPROT_LIMIT = 16'h0010
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WRITE,
  input  logic [15:0] ADDRESS,
  input  logic [15:0] DATA_IN,
  output logic [15:0] MMO,
  output logic        ACK,
  output logic        BUSY,
  output logic        WPROT_ERR
);

  localparam int unsigned       DEPTH       = 2 ** ADDR_W;
  localparam logic [3:0]        WAIT_INIT   = WAIT_STATES[3:0];
  localparam logic [ADDR_W-1:0] WPROT_FIRST = WPROT_LIMIT[ADDR_W-1:0];

`ifdef DUNC16_MEM_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_write;
  logic [15:0]       lat_data;

  logic [15:0]       mem [DEPTH];

  logic              completing;
  logic              wprot_hit;
  logic              mem_we;

  // The upper address bits alias onto the decoded range and are deliberately
  // dropped.
  if (ADDR_W < 16) begin : g_addr_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^ADDRESS[15:ADDR_W];
  end

  // The last edge of an access, when the array is written or read.
  assign completing = (state == ST_BUSY) && (wait_cnt == 4'd0);

  // A protected write still completes normally; it simply never reaches the
  // array.
  assign wprot_hit  = WPROT_ON && lat_write && (lat_addr < WPROT_FIRST);
  assign mem_we     = completing && lat_write && !wprot_hit;

  // NOTE: the storage array has no reset. Its contents survive RESET, and
  // leaving it out of the reset network lets it map onto RAM. An aborted
  // access cannot write, because an asserted reset forces state to ST_IDLE,
  // which clears mem_we.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[lat_addr] <= lat_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments, so every register
  // here samples the pre-edge values of the others, whatever order they are
  // written in.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_data  <= 16'h0000;
      MMO       <= 16'h0000;
      ACK       <= 1'b0;
      BUSY      <= 1'b0;
      WPROT_ERR <= 1'b0;
    end else begin
      // ACK and WPROT_ERR are single-cycle strobes.
      ACK       <= 1'b0;
      WPROT_ERR <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (REQ) begin
            lat_addr  <= ADDRESS[ADDR_W-1:0];
            lat_write <= WRITE;
            lat_data  <= DATA_IN;
            wait_cnt  <= WAIT_INIT;
            BUSY      <= 1'b1;
            state     <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            if (!lat_write) begin
              MMO <= mem[lat_addr];
            end
            ACK       <= 1'b1;
            WPROT_ERR <= wprot_hit;
            BUSY      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dunc16_mem_port.sv
// -----------------------------------------------------------------------------
// tb_dunc16_mem_port
//
// Self-checking bench for dunc16_mem_port. It instantiates two ports:
//   dut   default parameters (ADDR_W=8, WAIT_STATES=1)
//   dut0  WAIT_STATES=0, used for the back-to-back throughput sequence
// Expected values come from constant vector tables and from a word-array
// reference model of the port's documented behaviour.
// -----------------------------------------------------------------------------
module tb_dunc16_mem_port;

  localparam int WS  = 1;        // wait states of dut
  localparam int LAT = WS + 1;   // edges from acceptance to the ACK cycle

`ifdef DUNC16_MEM_WPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        REQ = 1'b0;
  logic        WRITE = 1'b0;
  logic [15:0] ADDRESS = 16'h0000;
  logic [15:0] DATA_IN = 16'h0000;
  logic [15:0] MMO;
  logic        ACK;
  logic        BUSY;
  logic        WPROT_ERR;

  logic        req0 = 1'b0;
  logic        write0 = 1'b0;
  logic [15:0] address0 = 16'h0000;
  logic [15:0] data_in0 = 16'h0000;
  logic [15:0] mmo0;
  logic        ack0;
  logic        busy0;
  logic        wprot_err0;

  dunc16_mem_port dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .DATA_IN(DATA_IN), .MMO(MMO), .ACK(ACK), .BUSY(BUSY), .WPROT_ERR(WPROT_ERR)
  );

  dunc16_mem_port #(.WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .REQ(req0), .WRITE(write0), .ADDRESS(address0),
    .DATA_IN(data_in0), .MMO(mmo0), .ACK(ack0), .BUSY(busy0), .WPROT_ERR(wprot_err0)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model: word array + MMO register ---------------
  logic [15:0] ref_mem   [256];
  bit          ref_valid [256];
  logic [15:0] ref_mmo = 16'h0000;

  function automatic bit ref_prot(input logic wr, input logic [15:0] a);
    return PROT && wr && (a[7:0] < 8'h10);
  endfunction

  task automatic ref_apply(input logic wr, input logic [15:0] a, input logic [15:0] d);
    if (wr) begin
      if (!ref_prot(wr, a)) begin
        ref_mem[a[7:0]]   = d;
        ref_valid[a[7:0]] = 1'b1;
      end
    end else begin
      ref_mmo = ref_mem[a[7:0]];
    end
  endtask

  // One access on dut. It reports the ACK latency in edges after acceptance
  // (-1 if no ACK arrived within the budget) and what it sampled.
  task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic busy_s, output logic busy_ack,
                        output logic [15:0] mmo_s, output logic err_s);
    @(negedge CLK);
    REQ = 1'b1; WRITE = wr; ADDRESS = a; DATA_IN = d;
    @(posedge CLK);
    lat = -1; busy_s = 1'b0; busy_ack = 1'b1; mmo_s = 16'hxxxx; err_s = 1'bx;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        // Scramble the inputs: they must be ignored once the access is accepted.
        REQ = 1'b0; WRITE = 1'($urandom); ADDRESS = 16'($urandom); DATA_IN = 16'($urandom);
        busy_s = BUSY;
      end
      if (ACK) begin
        lat = k; busy_ack = BUSY; mmo_s = MMO; err_s = WPROT_ERR;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input logic wr, input logic [15:0] a,
                               input logic [15:0] d, input logic [15:0] exp_mmo);
    int lat; logic bs, ba, er; logic [15:0] m;
    logic exp_err;
    exp_err = ref_prot(wr, a);
    access(wr, a, d, lat, bs, ba, m, er);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_busy"}, bs, 1'b1);
    check({tag, "_busy_at_ack"}, ba, 1'b0);
    check({tag, "_mmo"}, m, exp_mmo);
    check({tag, "_wprot_err"}, er, exp_err);
    ref_apply(wr, a, d);
  endtask

  // One write to dut0, whose WAIT_STATES is 0.
  task automatic wr0(input logic [15:0] a, input logic [15:0] d);
    @(negedge CLK);
    req0 = 1'b1; write0 = 1'b1; address0 = a; data_in0 = d;
    @(negedge CLK);
    req0 = 1'b0;
    check("b2b_pre_busy", busy0, 1'b1);
    @(negedge CLK);
    check("b2b_pre_ack", ack0, 1'b1);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_mmo;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [15:0] prior;
    logic [15:0] a, d, e;
    logic        wr;
    logic [15:0] b2b_addr [3];
    logic [15:0] b2b_data [3];

    vecs[0] = '{1'b1, 16'h0020, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 16'h0020, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 16'h0105, 16'h1234, 16'hBEEF};
    vecs[3] = '{1'b0, 16'h0005, 16'h0000, 16'h1234};
    vecs[4] = '{1'b1, 16'h0030, 16'h5555, 16'h1234};
    vecs[5] = '{1'b0, 16'h0030, 16'h0000, 16'h5555};
    vecs[6] = '{1'b0, 16'h1020, 16'h0000, 16'hBEEF};
    vecs[7] = '{1'b1, 16'h0020, 16'h0BAD, 16'hBEEF};

    // ---------------- reset ----------------
    repeat (2) @(negedge CLK);
    check("rst_ack", ACK, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_mmo", MMO, 16'h0000);
    RESET = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("idle_no_ack", ACK, 1'b0);
    end
    check("idle_wprot_err", WPROT_ERR, 1'b0);

    // ---------------- vector table ----------------
    for (int i = 0; i < 8; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
                    vecs[i].exp_mmo);
    end

    // ---------------- reset in the middle of a write ----------------
    @(negedge CLK);
    REQ = 1'b1; WRITE = 1'b1; ADDRESS = 16'h0030; DATA_IN = 16'hAAAA;
    @(posedge CLK);
    @(negedge CLK);
    REQ = 1'b0;
    check("midwr_busy", BUSY, 1'b1);
    RESET = 1'b0;
    #1;
    check("midwr_async_busy", BUSY, 1'b0);
    check("midwr_async_mmo", MMO, 16'h0000);
    repeat (2) begin
      @(negedge CLK);
      check("midwr_rst_no_ack", ACK, 1'b0);
    end
    RESET = 1'b1;
    ref_mmo = 16'h0000;
    repeat (3) begin
      @(negedge CLK);
      check("midwr_no_ack", ACK, 1'b0);
    end
    run_and_check("midwr_read", 1'b0, 16'h0030, 16'h0000, 16'h5555);

    // ---------------- write protection ----------------
`ifdef DUNC16_MEM_WPROT_EN
    begin
      int lat; logic bs, ba, er; logic [15:0] m;
      // A protected word cannot be preloaded through the port, so capture its
      // contents first and require that they survive the rejected write.
      access(1'b0, 16'h0004, 16'h0000, lat, bs, ba, m, er);
      check("wp_pre_latency", lat, LAT);
      prior = m;
      ref_mem[4] = prior; ref_valid[4] = 1'b1; ref_mmo = prior;
    end
    run_and_check("wp_write", 1'b1, 16'h0004, 16'hFFFF, prior);
    run_and_check("wp_read", 1'b0, 16'h0004, 16'h0000, prior);
`else
    prior = ref_mmo;
    run_and_check("wp_preload", 1'b1, 16'h0004, 16'h0001, prior);
    run_and_check("wp_write", 1'b1, 16'h0004, 16'hFFFF, prior);
    run_and_check("wp_read", 1'b0, 16'h0004, 16'h0000, 16'hFFFF);
`endif

    // ---------------- randomized accesses against the model ----------------
    for (int i = 0; i < 40; i++) begin
      a[15:8] = 8'($urandom);
      a[7:0]  = 8'h40 + 8'($urandom_range(0, 7));
      wr      = 1'($urandom_range(0, 1));
      if (!wr && !ref_valid[a[7:0]]) wr = 1'b1;
      d = 16'($urandom);
      e = wr ? ref_mmo : ref_mem[a[7:0]];
      run_and_check($sformatf("rnd%0d", i), wr, a, d, e);
    end

    // ---------------- back-to-back reads on dut0 (WAIT_STATES=0) ----------------
    b2b_addr[0] = 16'h0011; b2b_data[0] = 16'hC0DE;
    b2b_addr[1] = 16'h0012; b2b_data[1] = 16'h1357;
    b2b_addr[2] = 16'h0013; b2b_data[2] = 16'h2468;
    for (int i = 0; i < 3; i++) wr0(b2b_addr[i], b2b_data[i]);

    @(negedge CLK);
    req0 = 1'b1; write0 = 1'b0; address0 = b2b_addr[0];
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      check($sformatf("b2b_ack_%0d", k), ack0, (k % 2) == 1);
      check($sformatf("b2b_busy_%0d", k), busy0, (k % 2) == 0);
      if ((k % 2) == 1) check($sformatf("b2b_mmo_%0d", k), mmo0, b2b_data[k / 2]);
      if ((k % 2) == 0 && (k / 2 + 1) < 3) address0 = b2b_addr[k / 2 + 1];
      if (k == 5) req0 = 1'b0;
    end
    @(negedge CLK);
    check("b2b_end_ack", ack0, 1'b0);
    check("b2b_end_busy", busy0, 1'b0);
    check("b2b_wprot_err", wprot_err0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
